// File: rtl/sblk_act_feeder.sv
// Activation feeder for one systolic-block row.
// Packs pairs of stream words into double-width entries, queues them in a
// small FIFO and presents them to the row's activation-buffer write port.

`ifndef ACTBUF_DATA_LEN
`define ACTBUF_DATA_LEN 16
`endif

module sblk_act_feeder #(
    parameter int unsigned ACT_W      = `ACTBUF_DATA_LEN,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clk_l,
    input  logic                          rst,
    input  logic [ACT_W-1:0]              in_data,
    input  logic                          in_vld,
    input  logic                          in_last,
    output logic                          in_rdy,
    input  logic                          actbuf_wr_req,
    output logic                          actbuf_wr_vld,
    output logic [2*ACT_W-1:0]            actbuf_wr_data,
    input  logic                          flush,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic [CNT_W-1:0]              sent_cnt
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_FW = PTR_W + 1;
    localparam int unsigned ENT_W  = 2 * ACT_W;

    typedef enum logic {
        ST_LO = 1'b0,
        ST_HI = 1'b1
    } pk_state_t;

    pk_state_t              state_q;
    pk_state_t              state_d;
    logic [ACT_W-1:0]       lo_reg;
    logic                   lo_load;
    logic                   push;
    logic [ENT_W-1:0]       push_data;
    logic                   pop;
    logic                   beat;

    logic [ENT_W-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    // Ready depends only on registered occupancy and reset, never on in_vld
    always_comb begin
        in_rdy = ~rst & (fifo_cnt < CNT_FW'(FIFO_DEPTH));
        beat   = in_vld & in_rdy;
        pop    = actbuf_wr_req & (fifo_cnt != '0);
    end

    // Packer state register; flush returns to the low-word slot
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            state_q <= ST_LO;
        end else if (flush) begin
            state_q <= ST_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // Packer next state: a non-last low word waits for its high partner
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LO: if (beat && !in_last) state_d = ST_HI;
            ST_HI: if (beat)             state_d = ST_LO;
        endcase
    end

    // Packer outputs: odd tail words are zero-padded in the high half
    always_comb begin
        push      = 1'b0;
        push_data = '0;
        lo_load   = 1'b0;
        case (state_q)
            ST_LO: begin
                if (beat) begin
                    if (in_last) begin
                        push      = 1'b1;
                        push_data = {{ACT_W{1'b0}}, in_data};
                    end else begin
                        lo_load = 1'b1;
                    end
                end
            end
            ST_HI: begin
                if (beat) begin
                    push      = 1'b1;
                    push_data = {in_data, lo_reg};
                end
            end
        endcase
    end

    // Holding register for the pending low word
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            lo_reg <= '0;
        end else if (flush) begin
            lo_reg <= '0;
        end else if (lo_load) begin
            lo_reg <= in_data;
        end
    end

    // FIFO storage; a push coinciding with flush is dropped
    always_ff @(posedge clk_l) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_FW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_FW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Output register: head entry presented one cycle after the pop decision
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            actbuf_wr_vld  <= 1'b0;
            actbuf_wr_data <= '0;
        end else if (flush) begin
            actbuf_wr_vld  <= 1'b0;
            actbuf_wr_data <= '0;
        end else begin
            actbuf_wr_vld <= pop;
            if (pop) begin
                actbuf_wr_data <= mem[rd_ptr];
            end
        end
    end

    // Delivered-entry counter, wraps modulo 2^CNT_W
    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            sent_cnt <= '0;
        end else if (flush) begin
            sent_cnt <= '0;
        end else if (actbuf_wr_vld) begin
            sent_cnt <= sent_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/sblk_act_feeder.md
Name: sblk_act_feeder

Overview:
- Upstream activation feeder for one systolic-block row.
- Accepts a narrow activation stream (one ACT_W word per beat) and packs pairs of words into 2*ACT_W entries.
- Buffers packed entries in a small FIFO and delivers them to the row's activation-buffer write port under the row's actbuf_wr_req / actbuf_wr_vld handshake.
- One instance per row; sits between the off-chip/DMA activation stream and the row input.

Parameters:
ACT_W, `ACTBUF_DATA_LEN, width of one activation word; actbuf_wr_data is 2*ACT_W.
FIFO_DEPTH, 8, packed-entry FIFO depth; power of two, >=2.
CNT_W, 16, width of the delivered-entry counter.

Ports:
clk_l  input  1  row clock; all logic is in this domain.
rst  input  1  reset, asynchronous, active-high.
in_data  input  ACT_W  stream activation word.
in_vld  input  1  stream word valid.
in_last  input  1  last word of a tile; qualified by in_vld & in_rdy.
in_rdy  output  1  feeder can accept a stream word this cycle.
actbuf_wr_req  input  1  row requests data (level).
actbuf_wr_vld  output  1  actbuf_wr_data is valid this cycle (one entry per pulse).
actbuf_wr_data  output  2*ACT_W  packed entry: {hi word, lo word}.
flush  input  1  synchronous clear of FIFO, packer and counter.
fifo_cnt  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
sent_cnt  output  CNT_W  entries delivered since reset/flush; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, rst=1) and flush (sync, clk_l edge): all of the following are cleared.
  - FIFO pointers and count to 0.
  - Packer lo_pending to 0.
  - actbuf_wr_vld to 0 and actbuf_wr_data to 0.
  - sent_cnt to 0.
  - in_rdy is 0 while rst is high.
  - flush has priority over a same-cycle push or pop; that beat is discarded.
  - Reset mid-tile discards any half-packed word.
- Packer state machine, states LO and HI. Reset state is LO. A beat is in_vld & in_rdy.
  - LO, beat, in_last=0: store in_data in lo_reg; go to HI; no push.
  - LO, beat, in_last=1: push {ACT_W'0, in_data}; stay in LO (odd tile, zero-padded hi).
  - HI, beat: push {in_data, lo_reg}; go to LO, regardless of in_last.
  - No beat: state holds.
- in_rdy:
  - Equals (fifo_cnt < FIFO_DEPTH) in LO state.
  - Equals 1 in HI state only if fifo_cnt < FIFO_DEPTH.
  - Derived from registered count only. A same-cycle pop does not free space for a push that cycle.
  - in_rdy never depends on in_vld.
- Pop rule: pop = actbuf_wr_req & (fifo_cnt != 0), evaluated at the clk_l edge. The FIFO head is registered into actbuf_wr_data and actbuf_wr_vld=1 on the following cycle (latency 1 from req to vld).
  - If req stays high with data available, vld asserts on consecutive cycles, one distinct entry each.
  - No pop: vld=0 next cycle and actbuf_wr_data holds its last value.
  - req with an empty FIFO: no pop, no error, vld=0.
  - req deasserting does not cancel a pop already decided at the previous edge; that entry is still presented.
- FIFO:
  - Simultaneous push and pop leaves fifo_cnt unchanged; data order is preserved.
  - A push into a full FIFO cannot occur (in_rdy=0).
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_cnt ranges 0..FIFO_DEPTH.
- sent_cnt increments by 1 on every cycle in which actbuf_wr_vld=1, and wraps to 0 after 2^CNT_W-1.
- Output ordering: entries appear in stream order; lo word is in bits [ACT_W-1:0].

Test Plan:
- After reset, stream 0x0001..0x0004 (in_last on 0x0004) with actbuf_wr_req=0 -> fifo_cnt=2; then req=1 -> vld on the cycles after req, data 0x0002_0001 then 0x0004_0003; sent_cnt=2.
- Odd tile: stream 0x00AA (in_last=1) -> single entry 0x0000_00AA; packer back in LO; the next word 0x00BB pairs with a following word.
- Fill: 16 words with req=0 -> fifo_cnt=8 and in_rdy=0 while 17th word is held. Then hold req=1 for one cycle -> one entry popped, in_rdy=1 one cycle later.
- Simultaneous: FIFO at 4, push beat and req in the same cycle -> fifo_cnt stays 4; the popped entry is the oldest one.
- req=1 with FIFO empty for 5 cycles -> vld=0 throughout, sent_cnt unchanged. The first completed pair then appears 1 cycle after its push is visible in fifo_cnt.
- Assert rst asynchronously mid-tile (HI state, 3 entries queued) -> outputs zero immediately. After release, stream 0x0011, 0x0022 -> first entry 0x0022_0011; no stale data.
